i2c_scl_gen: RTL and testbench

Master-side bit-level bus engine for the I2C/SMBus core. Consumes the timing words produced by the register remap stage (ic_hcnt, ic_lcnt, ic_sda_hold, ic_enable) and executes START/RESTART/BIT/STOP commands from the byte controller, driving open-drain SCL/SDA enables. Handles slave clock stretching, samples received bits and detects arbitration loss.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_sync2.sv | 34 +++
 rtl/i2c_scl_gen.sv | 269 ++++++++++++++++++++++++++
 tb/tb_i2c_scl_gen.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings for the I2C master bit engine
// Purpose : command encodings, bit-engine state enum and the default width
//           of the timing counters, shared by the bit engine and its helpers.
// Ports   : none (package).
package i2c_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    CMD_START   = 2'd0,
    CMD_BIT     = 2'd1,
    CMD_STOP    = 2'd2,
    CMD_RESTART = 2'd3
  } cmd_e;

  // ST_HOLD : SDA low with SCL high (START/RESTART hold time)
  // ST_LOW  : SCL low, SDA updated at the hold point
  // ST_WAITH: SCL released, waiting for the bus to actually go high
  // ST_HIGH : SCL high period of a data bit
  // ST_SETUP: SCL high, setup time before STOP/RESTART SDA edge
  // ST_BUF  : bus free time after STOP
  // HOLD    : bus owned, SCL parked low between commands
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ST_HOLD  = 3'd1,
    ST_LOW   = 3'd2,
    ST_WAITH = 3'd3,
    ST_HIGH  = 3'd4,
    ST_SETUP = 3'd5,
    ST_BUF   = 3'd6,
    HOLD     = 3'd7
  } state_e;

endpackage

// File: rtl/i2c_sync2.sv
// rtl/i2c_sync2.sv - multi-stage synchronizer for raw pad inputs
// Purpose : brings an asynchronous pad level into the clk_i domain.
// Ports   : clk_i   - system clock
//           rstn_i  - async active-low reset (stages load RST_VAL)
//           async_i - raw asynchronous input
//           sync_o  - synchronized level, STAGES cycles of latency
module i2c_sync2
  import i2c_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic async_i,
  output logic sync_o
);

  // Never fewer than two flops, whatever the caller asks for.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ff_q <= {N{RST_VAL}};
    end else begin
      ff_q <= {ff_q[N-2:0], async_i};
    end
  end

  assign sync_o = ff_q[N-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// rtl/i2c_scl_gen.sv - I2C master bit-level bus engine
// Purpose : executes START/BIT/STOP/RESTART commands on open-drain SCL/SDA,
//           honours slave clock stretching, samples received bits and
//           detects arbitration loss.
// Ports   : clk_i, rstn_i          - clock, async active-low reset
//           ic_enable_i            - block enable; low aborts to IDLE
//           ic_hcnt_i, ic_lcnt_i   - SCL high/low periods in clk cycles
//           ic_sda_hold_i          - SDA hold after SCL fall, clk cycles
//           cmd_valid_i/cmd_i/cmd_data_i, cmd_ready_o - command handshake
//           done_o, rx_bit_o       - completion pulse and sampled bit
//           arb_lost_o, cmd_err_o  - arbitration-loss / illegal-cmd pulses
//           bus_owned_o            - high from START done to STOP done
//           scl_in_i, sda_in_i     - raw pad inputs
//           scl_oe_o, sda_oe_o     - 1 = pull line low
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             ic_enable_i,
  input  logic [CNT_W-1:0] ic_hcnt_i,
  input  logic [CNT_W-1:0] ic_lcnt_i,
  input  logic [CNT_W-1:0] ic_sda_hold_i,
  input  logic             cmd_valid_i,
  input  logic [1:0]       cmd_i,
  input  logic             cmd_data_i,
  output logic             cmd_ready_o,
  output logic             done_o,
  output logic             rx_bit_o,
  output logic             arb_lost_o,
  output logic             cmd_err_o,
  output logic             bus_owned_o,
  input  logic             scl_in_i,
  input  logic             sda_in_i,
  output logic             scl_oe_o,
  output logic             sda_oe_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic scl_s;
  logic sda_s;

  i2c_sync2 #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scl (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .async_i(scl_in_i),
    .sync_o (scl_s)
  );

  i2c_sync2 #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sda (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .async_i(sda_in_i),
    .sync_o (sda_s)
  );

  // Effective timing: zero periods behave as one, and the SDA hold point
  // must land strictly inside the low phase so SDA moves before SCL rises.
  logic [CNT_W-1:0] hcnt_eff, lcnt_eff, hold_lo, hold_eff;

  always_comb begin
    hcnt_eff = (ic_hcnt_i == '0) ? ONE : ic_hcnt_i;
    lcnt_eff = (ic_lcnt_i == '0) ? ONE : ic_lcnt_i;
    hold_lo  = (ic_sda_hold_i == '0) ? ONE : ic_sda_hold_i;
    hold_eff = (hold_lo > (lcnt_eff - ONE)) ? (lcnt_eff - ONE) : hold_lo;
  end

  state_e           state_q, state_d;
  cmd_e             op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d, hold_q, hold_d;
  logic             data_q, data_d;
  logic             scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic             rx_bit_q, rx_bit_d, owned_q, owned_d;
  logic             done_q, done_d, arb_q, arb_d, err_q, err_d;

  assign cmd_ready_o = ic_enable_i & ((state_q == IDLE) | (state_q == HOLD));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      op_q     <= CMD_START;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      hold_q   <= '0;
      data_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rx_bit_q <= 1'b0;
      owned_q  <= 1'b0;
      done_q   <= 1'b0;
      arb_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      hold_q   <= hold_d;
      data_q   <= data_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      rx_bit_q <= rx_bit_d;
      owned_q  <= owned_d;
      done_q   <= done_d;
      arb_q    <= arb_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    hold_d   = hold_q;
    data_d   = data_q;
    scl_oe_d = scl_oe_q;
    sda_oe_d = sda_oe_q;
    rx_bit_d = rx_bit_q;
    owned_d  = owned_q;
    done_d   = 1'b0;
    arb_d    = 1'b0;
    err_d    = 1'b0;

    if (!ic_enable_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      owned_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_i == CMD_START) begin
              op_d     = CMD_START;
              data_d   = cmd_data_i;
              hcnt_d   = hcnt_eff;
              lcnt_d   = lcnt_eff;
              hold_d   = hold_eff;
              cnt_d    = ONE;
              sda_oe_d = 1'b1;
              state_d  = ST_HOLD;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        HOLD: begin
          if (cmd_valid_i) begin
            // A START while the bus is already ours is a repeated start.
            op_d    = (cmd_i == CMD_START) ? CMD_RESTART : cmd_e'(cmd_i);
            data_d  = cmd_data_i;
            hcnt_d  = hcnt_eff;
            lcnt_d  = lcnt_eff;
            hold_d  = hold_eff;
            cnt_d   = ONE;
            state_d = ST_LOW;
          end
        end

        ST_HOLD: begin
          if (cnt_q == hcnt_q) begin
            scl_oe_d = 1'b1;
            owned_d  = 1'b1;
            done_d   = 1'b1;
            state_d  = HOLD;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end

        ST_LOW: begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == hold_q) begin
            case (op_q)
              CMD_BIT:  sda_oe_d = ~data_q;
              CMD_STOP: sda_oe_d = 1'b1;
              default:  sda_oe_d = 1'b0;
            endcase
          end
          if (cnt_q == lcnt_q) begin
            scl_oe_d = 1'b0;
            cnt_d    = ONE;
            state_d  = ST_WAITH;
          end
        end

        ST_WAITH: begin
          // Counter stays put while a slave stretches the clock.
          if (scl_s) begin
            cnt_d = ONE;
            if (op_q == CMD_BIT) begin
              rx_bit_d = sda_s;
              if (data_q && !sda_s) begin
                arb_d    = 1'b1;
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
                owned_d  = 1'b0;
                state_d  = IDLE;
              end else begin
                state_d = ST_HIGH;
              end
            end else begin
              state_d = ST_SETUP;
            end
          end
        end

        ST_HIGH: begin
          if (cnt_q == hcnt_q) begin
            scl_oe_d = 1'b1;
            done_d   = 1'b1;
            state_d  = HOLD;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end

        ST_SETUP: begin
          if (cnt_q == hcnt_q) begin
            cnt_d = ONE;
            if (op_q == CMD_STOP) begin
              sda_oe_d = 1'b0;
              state_d  = ST_BUF;
            end else begin
              sda_oe_d = 1'b1;
              state_d  = ST_HOLD;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end

        ST_BUF: begin
          if (cnt_q == lcnt_q) begin
            owned_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign done_o      = done_q;
  assign rx_bit_o    = rx_bit_q;
  assign arb_lost_o  = arb_q;
  assign cmd_err_o   = err_q;
  assign bus_owned_o = owned_q;
  assign scl_oe_o    = scl_oe_q;
  assign sda_oe_o    = sda_oe_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb/tb_i2c_scl_gen.sv - self-checking bench for the I2C master bit engine
module tb_i2c_scl_gen;
  import i2c_pkg::*;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;

  logic             clk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic             ic_enable_i = 1'b0;
  logic [CNT_W-1:0] ic_hcnt_i = '0;
  logic [CNT_W-1:0] ic_lcnt_i = '0;
  logic [CNT_W-1:0] ic_sda_hold_i = '0;
  logic             cmd_valid_i = 1'b0;
  logic [1:0]       cmd_i = 2'd0;
  logic             cmd_data_i = 1'b0;
  logic             cmd_ready_o, done_o, rx_bit_o, arb_lost_o, cmd_err_o, bus_owned_o;
  logic             scl_in_i, sda_in_i, scl_oe_o, sda_oe_o;
  logic             stretch_r = 1'b0;
  logic             force_r = 1'b0;

  // Open-drain bus: pull-ups, DUT drivers, a stretching slave and a rival master.
  assign scl_in_i = ~scl_oe_o & ~stretch_r;
  assign sda_in_i = ~sda_oe_o & ~force_r;

  i2c_scl_gen #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .ic_enable_i(ic_enable_i),
    .ic_hcnt_i(ic_hcnt_i), .ic_lcnt_i(ic_lcnt_i), .ic_sda_hold_i(ic_sda_hold_i),
    .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i), .cmd_data_i(cmd_data_i),
    .cmd_ready_o(cmd_ready_o), .done_o(done_o), .rx_bit_o(rx_bit_o),
    .arb_lost_o(arb_lost_o), .cmd_err_o(cmd_err_o), .bus_owned_o(bus_owned_o),
    .scl_in_i(scl_in_i), .sda_in_i(sda_in_i), .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: bus ownership and the level of our SDA driver.
  bit m_owned = 1'b0;
  bit m_sda = 1'b0;
  int exp_scl_q[$], exp_sda_q[$], obs_scl_q[$], obs_sda_q[$];
  int exp_done, exp_arb, exp_err, obs_done, obs_arb, obs_err;
  bit exp_rx, exp_rx_v, obs_rx;
  int last_acc;

  function automatic int eff(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int hold_clamp(input int v, input int l);
    int x;
    x = (v < 1) ? 1 : v;
    return (x > l - 1) ? l - 1 : x;
  endfunction

  // Expected line edges (absolute cycle numbers) for one command accepted at cycle a.
  // es is the cycle in which the engine first acts on SCL seen high.
  task automatic model_cmd(input int c, input bit d, input int s, input bit f, input int a);
    int h, l, ho, es;
    bit nb;
    h  = eff(int'(ic_hcnt_i));
    l  = eff(int'(ic_lcnt_i));
    ho = hold_clamp(int'(ic_sda_hold_i), l);
    es = a + l + s + SYNC + 1;
    exp_scl_q.delete(); exp_sda_q.delete();
    exp_done = -1; exp_arb = -1; exp_err = -1; exp_rx_v = 1'b0; exp_rx = 1'b0;
    if (!m_owned) begin
      if (c != 0) exp_err = a;
      else begin
        exp_sda_q.push_back(a); m_sda = 1'b1;
        exp_scl_q.push_back(a + h);
        exp_done = a + h; m_owned = 1'b1;
      end
    end else if (c == 1) begin
      nb = ~d;
      if (nb != m_sda) exp_sda_q.push_back(a + ho);
      m_sda = nb;
      exp_scl_q.push_back(a + l);
      if (d && f) begin
        exp_arb = es; m_owned = 1'b0;
      end else begin
        exp_scl_q.push_back(es + h);
        exp_done = es + h; exp_rx = d & ~f; exp_rx_v = 1'b1;
      end
    end else if (c == 2) begin
      if (!m_sda) exp_sda_q.push_back(a + ho);
      exp_scl_q.push_back(a + l);
      exp_sda_q.push_back(es + h); m_sda = 1'b0;
      exp_done = es + h + l; m_owned = 1'b0;
    end else begin
      if (m_sda) exp_sda_q.push_back(a + ho);
      exp_scl_q.push_back(a + l);
      exp_sda_q.push_back(es + h); m_sda = 1'b1;
      exp_scl_q.push_back(es + 2 * h);
      exp_done = es + 2 * h;
    end
  endtask

  // Issues one command, plays the bus environment, scores the outcome.
  // Starts and ends on a falling clock edge.
  task automatic do_cmd(input string tag, input int c, input bit d, input int s, input bit f);
    bit ls, ld, ev;
    int fall_t, a;
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL %s ready: got %b want 1", tag, cmd_ready_o);
    end
    ls = scl_oe_o; ld = sda_oe_o;
    obs_scl_q.delete(); obs_sda_q.delete();
    obs_done = -1; obs_arb = -1; obs_err = -1; obs_rx = 1'b0;
    cmd_valid_i = 1'b1; cmd_i = 2'(c); cmd_data_i = d;
    @(negedge clk_i);
    a = cyc; last_acc = a;
    cmd_valid_i = 1'b0;
    model_cmd(c, d, s, f, a);
    ev = 1'b0; fall_t = -1;
    for (int i = 0; i < 800 && !ev; i++) begin
      if (i > 0) @(negedge clk_i);
      if (scl_oe_o !== ls) begin
        obs_scl_q.push_back(cyc); ls = scl_oe_o;
        if (!ls) begin
          fall_t = cyc;
          if (s > 0) stretch_r = 1'b1;
          if (f) force_r = 1'b1;
        end
      end
      if (stretch_r && cyc == fall_t + s) stretch_r = 1'b0;
      if (sda_oe_o !== ld) begin obs_sda_q.push_back(cyc); ld = sda_oe_o; end
      if (done_o === 1'b1)     begin obs_done = cyc; obs_rx = rx_bit_o; ev = 1'b1; end
      if (arb_lost_o === 1'b1) begin obs_arb = cyc; ev = 1'b1; end
      if (cmd_err_o === 1'b1)  begin obs_err = cyc; ev = 1'b1; end
    end
    stretch_r = 1'b0; force_r = 1'b0;

    n_cmp++;
    if (!ev) begin n_bad++; $display("FAIL %s timeout: no done/arb/err in 800 cycles", tag); end
    n_cmp++;
    if (obs_scl_q.size() != exp_scl_q.size()) begin
      n_bad++; $display("FAIL %s scl_oe edge count: got %0d want %0d", tag, obs_scl_q.size(), exp_scl_q.size());
    end else begin
      foreach (exp_scl_q[k]) begin
        n_cmp++;
        if (obs_scl_q[k] != exp_scl_q[k]) begin
          n_bad++; $display("FAIL %s scl_oe edge %0d: got +%0d want +%0d", tag, k, obs_scl_q[k] - a, exp_scl_q[k] - a);
        end
      end
    end
    n_cmp++;
    if (obs_sda_q.size() != exp_sda_q.size()) begin
      n_bad++; $display("FAIL %s sda_oe edge count: got %0d want %0d", tag, obs_sda_q.size(), exp_sda_q.size());
    end else begin
      foreach (exp_sda_q[k]) begin
        n_cmp++;
        if (obs_sda_q[k] != exp_sda_q[k]) begin
          n_bad++; $display("FAIL %s sda_oe edge %0d: got +%0d want +%0d", tag, k, obs_sda_q[k] - a, exp_sda_q[k] - a);
        end
      end
    end
    n_cmp++;
    if (obs_done != exp_done) begin n_bad++; $display("FAIL %s done cycle: got %0d want %0d", tag, obs_done - a, exp_done - a); end
    n_cmp++;
    if (obs_arb != exp_arb) begin n_bad++; $display("FAIL %s arb_lost cycle: got %0d want %0d", tag, obs_arb - a, exp_arb - a); end
    n_cmp++;
    if (obs_err != exp_err) begin n_bad++; $display("FAIL %s cmd_err cycle: got %0d want %0d", tag, obs_err - a, exp_err - a); end
    if (exp_rx_v) begin
      n_cmp++;
      if (obs_rx !== exp_rx) begin n_bad++; $display("FAIL %s rx_bit: got %b want %b", tag, obs_rx, exp_rx); end
    end
    n_cmp++;
    if (bus_owned_o !== m_owned) begin n_bad++; $display("FAIL %s bus_owned: got %b want %b", tag, bus_owned_o, m_owned); end
  endtask

  task automatic set_timing(input int h, input int l, input int ho);
    ic_hcnt_i = CNT_W'(h); ic_lcnt_i = CNT_W'(l); ic_sda_hold_i = CNT_W'(ho);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    string nm [8];
    nm = '{"cmd_ready", "bus_owned", "cmd_err", "arb_lost", "rx_bit", "done", "sda_oe", "scl_oe"};
    rstn_i = 1'b0; ic_enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    v = {scl_oe_o, sda_oe_o, done_o, rx_bit_o, arb_lost_o, cmd_err_o, bus_owned_o, cmd_ready_o};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (v[i] !== 1'b0) begin n_bad++; $display("FAIL reset %s: got %b want 0", nm[i], v[i]); end
    end
    rstn_i = 1'b1;
    @(negedge clk_i);
    ic_enable_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset ready_after_enable: got %b want 1", cmd_ready_o); end
    m_owned = 1'b0; m_sda = 1'b0;
  endtask

  task automatic test_start();
    set_timing(10, 20, 3);
    do_cmd("start", 0, 1'b0, 0, 1'b0);
    if (obs_scl_q.size() == 1) begin
      n_cmp++;
      if (obs_scl_q[0] - last_acc != 10) begin n_bad++; $display("FAIL start scl_low_delay: got %0d want 10", obs_scl_q[0] - last_acc); end
    end
    @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b0) begin n_bad++; $display("FAIL start done_width: got %b want 0", done_o); end
  endtask

  task automatic test_bits();
    do_cmd("bit0", 1, 1'b0, 0, 1'b0);
    do_cmd("bit1", 1, 1'b1, 0, 1'b0);
    if (obs_sda_q.size() == 1) begin
      n_cmp++;
      if (obs_sda_q[0] - last_acc != 3) begin n_bad++; $display("FAIL bit1 sda_hold: got %0d want 3", obs_sda_q[0] - last_acc); end
    end
  endtask

  task automatic test_stretch();
    do_cmd("stretch", 1, 1'b1, 50, 1'b0);
  endtask

  task automatic test_arb();
    do_cmd("arb", 1, 1'b1, 0, 1'b1);
    n_cmp++;
    if ({cmd_ready_o, scl_oe_o, sda_oe_o} !== 3'b100) begin
      n_bad++; $display("FAIL arb lines/ready: got %b want 100", {cmd_ready_o, scl_oe_o, sda_oe_o});
    end
  endtask

  task automatic test_stop();
    do_cmd("stop_start", 0, 1'b0, 0, 1'b0);
    do_cmd("stop_bit", 1, 1'b0, 0, 1'b0);
    do_cmd("stop", 2, 1'b0, 0, 1'b0);
    do_cmd("idle_bit_err", 1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_restart();
    do_cmd("rs_start", 0, 1'b0, 0, 1'b0);
    do_cmd("rs_bit1", 1, 1'b1, 0, 1'b0);
    do_cmd("restart", 3, 1'b0, 0, 1'b0);
    do_cmd("rs_bit0", 1, 1'b0, 0, 1'b0);
    do_cmd("start_in_hold", 0, 1'b0, 3, 1'b0);
    do_cmd("rs_stop", 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_enable_drop();
    bit seen;
    int a;
    do_cmd("en_start", 0, 1'b0, 0, 1'b0);
    cmd_valid_i = 1'b1; cmd_i = 2'(CMD_BIT); cmd_data_i = 1'b0;
    @(negedge clk_i);
    a = cyc; cmd_valid_i = 1'b0; seen = 1'b0;
    for (int i = 0; i < 200 && cyc < a + 20 + SYNC + 1 + 4; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if ({scl_oe_o, sda_oe_o} !== 2'b01) begin n_bad++; $display("FAIL en_drop pre_state: got %b want 01", {scl_oe_o, sda_oe_o}); end
    ic_enable_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({scl_oe_o, sda_oe_o, bus_owned_o, cmd_ready_o} !== 4'b0000) begin
      n_bad++; $display("FAIL en_drop released: got %b want 0000", {scl_oe_o, sda_oe_o, bus_owned_o, cmd_ready_o});
    end
    ic_enable_i = 1'b1;
    repeat (15) begin
      @(negedge clk_i);
      if (done_o === 1'b1 || scl_oe_o === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL en_drop quiet: got activity 1 want 0"); end
    m_owned = 1'b0; m_sda = 1'b0;
    do_cmd("en_idle_err", 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_clamp();
    set_timing(10, 20, 0);
    do_cmd("clamp_start", 0, 1'b0, 0, 1'b0);
    do_cmd("clamp_lo", 1, 1'b1, 0, 1'b0);
    n_cmp++;
    if (obs_sda_q.size() != 1 || obs_sda_q[0] - last_acc != 1) begin
      n_bad++; $display("FAIL clamp_lo hold: got %0d want 1", (obs_sda_q.size() > 0) ? obs_sda_q[0] - last_acc : -1);
    end
    set_timing(10, 20, 40);
    do_cmd("clamp_hi", 1, 1'b0, 0, 1'b0);
    n_cmp++;
    if (obs_sda_q.size() != 1 || obs_sda_q[0] - last_acc != 19) begin
      n_bad++; $display("FAIL clamp_hi hold: got %0d want 19", (obs_sda_q.size() > 0) ? obs_sda_q[0] - last_acc : -1);
    end
    do_cmd("clamp_stop", 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    int c, s;
    bit d, f;
    for (int it = 0; it < 40; it++) begin
      set_timing($urandom_range(0, 12), $urandom_range(2, 16), $urandom_range(0, 20));
      if (!m_owned) begin
        c = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
        do_cmd("rnd_idle", c, 1'b0, 0, 1'b0);
      end else begin
        c = $urandom_range(0, 3);
        d = 1'($urandom_range(0, 1));
        s = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
        f = (c == 1) && ($urandom_range(0, 5) == 0);
        do_cmd("rnd_bus", c, d, s, f);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_bits();
    test_stretch();
    test_arb();
    test_stop();
    test_restart();
    test_enable_drop();
    test_clamp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
